// File: rtl/pwm_pkg.sv
// Shared types and widths for the PWM measurement block: FSM states,
// counter widths and saturating arithmetic helpers.
package pwm_pkg;

  localparam int DUTY_W = 11;
  localparam int CNT_W  = 12;

  localparam logic [DUTY_W-1:0] DUTY_MAX = 11'd2047;
  localparam logic [CNT_W-1:0]  CNT_MAX  = 12'd4095;

  typedef enum logic [1:0] {
    SEARCH,
    HIGH,
    LOW
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 12'd1;
  endfunction

  // Counters run to 4095 but the duty output is only 11 bits wide.
  function automatic logic [DUTY_W-1:0] clip_duty(input logic [CNT_W-1:0] v);
    return (v > {1'b0, DUTY_MAX}) ? DUTY_MAX : v[DUTY_W-1:0];
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous input followed by an edge
// register; rise/fall are single-cycle strobes in the clk domain.
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic lvl,
  output logic rise,
  output logic fall
);

  logic meta;
  logic sync;
  logic prev;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour, which is what makes this a shift chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
    end else begin
      meta <= din;
      sync <= meta;
      prev <= sync;
    end
  end

  assign lvl  = sync;
  assign rise = sync & ~prev;
  assign fall = ~sync & prev;

endmodule

// File: rtl/pwm_decode.sv
// Measures high time and rising-to-rising period of an asynchronous PWM line,
// and flags loss of signal when no rising edge arrives within TIMEOUT cycles.
module pwm_decode
  import pwm_pkg::*;
#(
  parameter int TIMEOUT = 4095
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pwm_in,
  output logic [DUTY_W-1:0] duty,
  output logic [CNT_W-1:0]  period,
  output logic              meas_vld,
  output logic              sig_lost,
  output logic              stuck_hi
);

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  logic lvl;
  logic rise;
  logic fall;

  sync_edge u_sync_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (pwm_in),
    .lvl   (lvl),
    .rise  (rise),
    .fall  (fall)
  );

  state_t           state;
  state_t           state_d;
  logic [CNT_W-1:0] hi_cnt;
  logic [CNT_W-1:0] hi_d;
  logic [CNT_W-1:0] per_cnt;
  logic [CNT_W-1:0] per_d;
  logic             publish;
  logic             lose;
  logic             timeout;

  // >= rather than == so a counter that ran past TIMEOUT still expires.
  assign timeout = (per_cnt >= TIMEOUT_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= SEARCH;
      hi_cnt  <= '0;
      per_cnt <= '0;
    end else begin
      state   <= state_d;
      hi_cnt  <= hi_d;
      per_cnt <= per_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d = state;
    hi_d    = hi_cnt;
    per_d   = per_cnt;
    publish = 1'b0;
    lose    = 1'b0;
    unique case (state)
      SEARCH: begin
        hi_d  = '0;
        per_d = '0;
        if (rise) begin
          state_d = HIGH;
          hi_d    = CNT_W'(1);
          per_d   = CNT_W'(1);
        end
      end
      HIGH: begin
        hi_d  = sat_inc(hi_cnt);
        per_d = sat_inc(per_cnt);
        if (fall) begin
          // The falling-edge cycle itself does not count as high time.
          state_d = LOW;
          hi_d    = hi_cnt;
        end else if (timeout) begin
          state_d = SEARCH;
          hi_d    = '0;
          per_d   = '0;
          lose    = 1'b1;
        end
      end
      LOW: begin
        per_d = sat_inc(per_cnt);
        if (rise) begin
          state_d = HIGH;
          hi_d    = CNT_W'(1);
          per_d   = CNT_W'(1);
          publish = 1'b1;
        end else if (timeout) begin
          state_d = SEARCH;
          hi_d    = '0;
          per_d   = '0;
          lose    = 1'b1;
        end
      end
      default: begin
        state_d = SEARCH;
        hi_d    = '0;
        per_d   = '0;
      end
    endcase
  end

  // Results register on the edge-detect cycle, so meas_vld lines up with the
  // first cycle the new duty/period are visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty     <= '0;
      period   <= '0;
      meas_vld <= 1'b0;
      sig_lost <= 1'b0;
      stuck_hi <= 1'b0;
    end else begin
      meas_vld <= publish;
      if (publish) begin
        duty     <= clip_duty(hi_cnt);
        period   <= per_cnt;
        sig_lost <= 1'b0;
      end
      if (lose) begin
        sig_lost <= 1'b1;
        stuck_hi <= lvl;
      end else if (state == SEARCH && sig_lost) begin
        stuck_hi <= lvl;
      end
    end
  end

endmodule

// File: tb/tb_pwm_decode.sv
// Scoreboarded bench for pwm_decode: a pulse-level model predicts every
// measurement and loss event with its cycle; a monitor checks what the DUT shows.
module tb_pwm_decode;
  import pwm_pkg::*;

  localparam int TO  = 4095;
  localparam int LAT = 3;   // pwm_in drive to visible output, in clk edges

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              pwm_in = 1'b0;
  logic [DUTY_W-1:0] duty;
  logic [CNT_W-1:0]  period;
  logic              meas_vld;
  logic              sig_lost;
  logic              stuck_hi;

  pwm_decode #(.TIMEOUT(TO)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pwm_in   (pwm_in),
    .duty     (duty),
    .period   (period),
    .meas_vld (meas_vld),
    .sig_lost (sig_lost),
    .stuck_hi (stuck_hi)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit lost;
    int cyc;
    int duty;
    int period;
    bit stuck;
  } ev_t;

  ev_t sb[$];
  ev_t mon_e;
  int  last_duty   = 0;
  int  last_period = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One PWM period starting at the current negedge: h cycles high, l low.
  // The rise here is published at the next rise unless the gap exceeds TO.
  task automatic pulse(input int h, input int l);
    ev_t e;
    int  n;
    n = cyc;
    if (h + l > TO) begin
      e = '{lost: 1'b1, cyc: n + LAT + TO, duty: last_duty, period: last_period,
            stuck: (h > TO)};
    end else begin
      e = '{lost: 1'b0, cyc: n + LAT + h + l, duty: (h > 2047) ? 2047 : h,
            period: h + l, stuck: 1'b0};
      last_duty   = e.duty;
      last_period = e.period;
    end
    sb.push_back(e);
    pwm_in = 1'b1;
    repeat (h) @(negedge clk);
    pwm_in = 1'b0;
    repeat (l) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_duty"},     32'(duty),     0);
    check({tag, "_period"},   32'(period),   0);
    check({tag, "_meas_vld"}, 32'(meas_vld), 0);
    check({tag, "_sig_lost"}, 32'(sig_lost), 0);
    check({tag, "_stuck_hi"}, 32'(stuck_hi), 0);
  endtask

  logic lost_q = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      lost_q <= 1'b0;
    end else begin
      if (meas_vld || (sig_lost && !lost_q)) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: meas_vld=%0b sig_lost=%0b at cycle %0d, expected none",
                   meas_vld, sig_lost, cyc);
        end else begin
          mon_e = sb.pop_front();
          check("event_kind",  32'(!meas_vld), 32'(mon_e.lost));
          check("event_cycle", cyc,            mon_e.cyc);
          check("duty",        32'(duty),      mon_e.duty);
          check("period",      32'(period),    mon_e.period);
          if (mon_e.lost) check("stuck_hi", 32'(stuck_hi), 32'(mon_e.stuck));
          else            check("sig_lost_clear", 32'(sig_lost), 0);
        end
      end else if (sb.size() != 0 && sb[0].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL missed_event: lost=%0b expected at cycle %0d, still absent at cycle %0d",
                 sb[0].lost, sb[0].cyc, cyc);
        void'(sb.pop_front());
      end
      lost_q <= sig_lost;
    end
  end

  initial begin
    rst_n  = 1'b0;
    pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    repeat (5) pulse(1024, 1024);
    repeat (3) pulse(3000, 1000);
    repeat (3) pulse(1, 99);
    for (int i = 0; i < 30; i++) pulse(int'($urandom_range(1, 300)), int'($urandom_range(1, 300)));

    // Period exactly TO: the edge beats the timeout.
    pulse(100, TO - 100);
    // Line stuck low, then recovery.
    pulse(200, 4500);
    repeat (2) pulse(500, 500);
    // Line stuck high.
    pulse(4200, 300);
    repeat (2) pulse(700, 300);

    // Reset in the middle of a high phase; the partial period is discarded.
    pwm_in = 1'b1;
    repeat (400) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    sb.delete();
    last_duty   = 0;
    last_period = 0;
    @(negedge clk);
    pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("held_rst");
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    repeat (3) pulse(600, 400);
    pulse(50, 4200);

    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    repeat (20) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
